lab9_soc_pio_in_irq: RTL

//  Parametrised Avalon-MM input PIO for the lab9 SoC; next generation of the buttons/switches PIO.

---
 rtl/lab9_soc_pio_in_irq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lab9_soc_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : lab9_soc_pio_in_irq
// Description : Avalon-MM input PIO for the lab9 SoC. Synchronises a WIDTH-bit
//               asynchronous input bus, optionally debounces it, detects edges
//               into a sticky edge-capture register and raises a maskable,
//               level-sensitive interrupt. Register map (word address):
//               0 data, 1 reserved (reads 0), 2 irqmask, 3 edgecapture.
//               Optional feature macro: PIO_DEBOUNCE_EN (per-bit stability
//               counters of DEBOUNCE_CYCLES clk cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module lab9_soc_pio_in_irq #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  w_stable;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  w_edge;
    logic [WIDTH-1:0]                  w_clear;
    logic [WIDTH-1:0]                  r_edgecap;
    logic [WIDTH-1:0]                  r_irqmask;
    logic [31:0]                       w_rd_mux;
    logic                              w_wr;

    assign w_wr   = chipselect & ~write_n;
    assign w_sync = r_sync[SYNC_STAGES-1];

    // Bits of writedata above the bus width carry no meaning
    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Multi-flop synchroniser: stage 0 samples the pins, last stage is safe to use
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]              r_stable;
    logic [WIDTH-1:0][c_CNT_W-1:0] r_cnt;

    // Per-bit debounce: accept a new level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_LAST) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = w_sync;
`endif

    // Edge polarity selected at elaboration time
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge = w_stable & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~w_stable & r_prev;
        end else begin : g_edge_any
            assign w_edge = w_stable ^ r_prev;
        end
    endgenerate

    // Bits to clear in edgecapture: write-one-to-clear at address 3
    assign w_clear = (w_wr && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // Previous stable value, sticky edge capture (set beats clear) and irq mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= '0;
            r_edgecap <= '0;
            r_irqmask <= RESET_MASK;
        end else begin
            r_prev    <= w_stable;
            r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
            if (w_wr && (address == c_ADDR_MASK)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux, zero-extended; reserved address reads as zero
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_stable;
            c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            c_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:     w_rd_mux            = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    // Interrupt built purely from flop outputs so it cannot glitch
    assign irq = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire
